// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares the single unified memory port between the core
// and a secondary (debug/DMA) master. One transaction at a time, round-robin
// on ties, req/ack handshake toward memory with a watchdog timeout.
module memory_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset,
  // core master
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_format,
  output logic        core_ready,
  output logic [31:0] core_rdata,
  // secondary master
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [2:0]  dma_format,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_format,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FMT_W    = 3;
  localparam logic [FMT_W-1:0] FMT_WORD = 3'b010;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {GNT_CORE, GNT_DMA} gnt_e;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [FMT_W-1:0]  format;
  } mem_cmd_t;

  localparam mem_cmd_t CMD_RESET = '{we: 1'b0, addr: '0, wdata: '0, format: FMT_WORD};

  state_e               state_q, state_d;
  gnt_e                 last_q, last_d;
  gnt_e                 grant_q, grant_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  mem_cmd_t             cmd_q, cmd_d;

  mem_cmd_t          core_cmd;
  mem_cmd_t          dma_cmd;
  logic              timeout_hit;
  logic              done;
  logic [DATA_W-1:0] rdata_sel;

  assign core_cmd = '{we: core_we, addr: core_addr, wdata: core_wdata, format: core_format};
  assign dma_cmd  = '{we: dma_we,  addr: dma_addr,  wdata: dma_wdata,  format: dma_format};

  // Watchdog expires on the last allowed request cycle
  assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Memory-side outputs are decodes of registered state only
  assign mem_req    = (state_q == BUSY);
  assign mem_we     = cmd_q.we;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;
  assign mem_format = cmd_q.format;

  // State, grant bookkeeping, watchdog and latched command
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GNT_DMA;
      grant_q <= GNT_CORE;
      cnt_q   <= '0;
      cmd_q   <= CMD_RESET;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

  // Arbitration, completion/timeout detection and ready/rdata steering
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    done       = 1'b0;
    rdata_sel  = '0;
    bus_error  = 1'b0;
    core_ready = 1'b0;
    dma_ready  = 1'b0;
    core_rdata = '0;
    dma_rdata  = '0;

    case (state_q)
      IDLE: begin
        // core wins unless dma also requests and core won last time
        if (core_req && (!dma_req || (last_q == GNT_DMA))) begin
          grant_d = GNT_CORE;
          cmd_d   = core_cmd;
          cnt_d   = '0;
          state_d = BUSY;
        end else if (dma_req) begin
          grant_d = GNT_DMA;
          cmd_d   = dma_cmd;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // an ack in the final watchdog cycle still completes normally
        if (mem_ack) begin
          done      = 1'b1;
          rdata_sel = mem_rdata;
          last_d    = grant_q;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          done      = 1'b1;
          bus_error = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (grant_q == GNT_CORE) begin
        core_ready = 1'b1;
        core_rdata = rdata_sel;
      end else begin
        dma_ready = 1'b1;
        dma_rdata = rdata_sel;
      end
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter. A second instance with a short
// watchdog shares the stimulus and is checked only in the timeout scenarios.
module tb_memory_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req, core_we, dma_req, dma_we, mem_ack;
  logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [2:0]  core_format, dma_format;

  logic        core_ready, dma_ready, mem_req, mem_we, bus_error;
  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_format;

  logic        t4_core_ready, t4_dma_ready, t4_mem_req, t4_mem_we, t4_bus_error;
  logic [31:0] t4_core_rdata, t4_dma_rdata, t4_mem_addr, t4_mem_wdata;
  logic [2:0]  t4_mem_format;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  memory_port_arbiter u_dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_format(core_format),
    .core_ready(core_ready), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_format(dma_format),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_format(mem_format),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_error(bus_error)
  );

  memory_port_arbiter #(.TIMEOUT_CYCLES(4)) u_dut_t4 (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_format(core_format),
    .core_ready(t4_core_ready), .core_rdata(t4_core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_format(dma_format),
    .dma_ready(t4_dma_ready), .dma_rdata(t4_dma_rdata),
    .mem_req(t4_mem_req), .mem_we(t4_mem_we), .mem_addr(t4_mem_addr),
    .mem_wdata(t4_mem_wdata), .mem_format(t4_mem_format),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_error(t4_bus_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_format = 3'b010;
    dma_req  = 0; dma_we  = 0; dma_addr  = '0; dma_wdata  = '0; dma_format  = 3'b010;
    mem_ack = 0; mem_rdata = '0;
    step(); step();
    reset = 1'b0;

    // reset while a core read is pending
    core_req = 1; core_addr = 32'h40;
    step();
    #1 check("t1_busy_req", 32'(mem_req), 32'd1);
    core_req = 0;
    step();
    reset = 1'b1;
    #1 check("t1_no_ready_before_rst", 32'(core_ready), 32'd0);
    step();
    reset = 1'b0;
    #1 check("t1_req_after_rst", 32'(mem_req), 32'd0);
    check("t1_ready_after_rst", 32'(core_ready), 32'd0);
    check("t1_fmt_after_rst", 32'(mem_format), 32'h2);
    check("t1_addr_after_rst", mem_addr, 32'h0);
    step();
    check("t1_idle_stays", 32'(mem_req), 32'd0);

    // single core read, ack one cycle after mem_req rises
    core_req = 1; core_we = 0; core_addr = 32'h100; core_format = 3'b010;
    step();
    core_req = 0;
    #1 check("t2_req", 32'(mem_req), 32'd1);
    check("t2_addr", mem_addr, 32'h100);
    check("t2_no_early_ready", 32'(core_ready), 32'd0);
    step();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1 check("t2_ready", 32'(core_ready), 32'd1);
    check("t2_rdata", core_rdata, 32'hDEADBEEF);
    check("t2_dma_ready", 32'(dma_ready), 32'd0);
    check("t2_dma_rdata", dma_rdata, 32'h0);
    step();
    mem_ack = 0;
    #1 check("t2_idle", 32'(mem_req), 32'd0);
    check("t2_single_pulse", 32'(core_ready), 32'd0);

    // continuous contention with zero-wait memory alternates grants
    do_reset();
    core_req = 1; core_addr = 32'h10;
    dma_req  = 1; dma_addr  = 32'h20;
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 4; i++) begin
      step();
      #1 check($sformatf("t3_req_%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("t3_addr_%0d", i), mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      check($sformatf("t3_rdy_%0d", i), {30'd0, dma_ready, core_ready},
            (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      #1 check($sformatf("t3_gap_%0d", i), {29'd0, mem_req, dma_ready, core_ready}, 32'd0);
    end
    core_req = 0; dma_req = 0; mem_ack = 0;
    step();

    // dma write with five wait cycles keeps the command stable
    dma_req = 1; dma_we = 1; dma_addr = 32'h2000; dma_wdata = 32'h12345678; dma_format = 3'b000;
    step();
    dma_req = 0; dma_we = 0; dma_addr = 32'hFFFF; dma_wdata = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin mem_ack = 1; mem_rdata = 32'h0; end
      #1 check($sformatf("t4_addr_c%0d", c), mem_addr, 32'h2000);
      check($sformatf("t4_wdata_c%0d", c), mem_wdata, 32'h12345678);
      check($sformatf("t4_ctl_c%0d", c),
            {26'd0, mem_req, mem_we, mem_format, dma_ready, core_ready},
            {26'd0, 1'b1, 1'b1, 3'b000, (c == 6), 1'b0});
      step();
    end
    mem_ack = 0;
    #1 check("t4_idle", 32'(mem_req), 32'd0);

    // watchdog expiry with no ack (4-cycle instance)
    do_reset();
    core_req = 1; core_addr = 32'h300; core_format = 3'b010;
    mem_rdata = 32'hFFFFFFFF;
    step();
    core_req = 0;
    for (int c = 1; c <= 4; c++) begin
      #1 check($sformatf("t5_ctl_c%0d", c), {29'd0, t4_mem_req, t4_core_ready, t4_bus_error},
               {29'd0, 1'b1, (c == 4), (c == 4)});
      if (c == 4) check("t5_rdata_zero", t4_core_rdata, 32'h0);
      step();
    end
    #1 check("t5_idle", {30'd0, t4_mem_req, t4_bus_error}, 32'd0);

    // ack landing in the final watchdog cycle wins over the timeout
    do_reset();
    core_req = 1; core_addr = 32'h304;
    step();
    core_req = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin mem_ack = 1; mem_rdata = 32'hCAFEF00D; end
      #1 check($sformatf("t5b_ctl_c%0d", c), {29'd0, t4_mem_req, t4_core_ready, t4_bus_error},
               {29'd0, 1'b1, (c == 4), 1'b0});
      if (c == 4) check("t5b_rdata", t4_core_rdata, 32'hCAFEF00D);
      step();
    end
    mem_ack = 0;
    #1 check("t5b_idle", 32'(t4_mem_req), 32'd0);

    // core drops req mid-transaction while dma starts requesting
    core_req = 1; core_addr = 32'h400;
    step();
    core_req = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h500; dma_format = 3'b010;
    #1 check("t6_core_addr", mem_addr, 32'h400);
    step();
    mem_ack = 1; mem_rdata = 32'h11;
    #1 check("t6_core_ready", {30'd0, dma_ready, core_ready}, 32'd1);
    check("t6_core_rdata", core_rdata, 32'h11);
    step();
    mem_ack = 0;
    #1 check("t6_gap", 32'(mem_req), 32'd0);
    step();
    dma_req = 0;
    #1 check("t6_dma_grant", 32'(mem_req), 32'd1);
    check("t6_dma_addr", mem_addr, 32'h500);
    mem_ack = 1; mem_rdata = 32'h22;
    #1 check("t6_dma_ready", {30'd0, dma_ready, core_ready}, 32'd2);
    check("t6_dma_rdata", dma_rdata, 32'h22);
    check("t6_core_rdata_zero", core_rdata, 32'h0);
    step();
    mem_ack = 0;
    #1 check("t6_end_idle", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
